// File: rtl/regfile_access_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_access_arbiter
//   Shares one register-file write port and one read port among num_req
//   requesters. Round-robin grant, valid/ready command handshake, one command
//   in flight at a time, registered read response.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester command handshake (ready is one-hot or 0)
//   req_write         per-requester op: 1 = write, 0 = read
//   req_addr/wdata    packed per-requester address / write data
//   rsp_valid         one-cycle read-response strobe to the owning requester
//   rsp_data          shared read data, held until the next read capture
//   busy              high whenever the FSM is not idle
//   rf_*              register-file port; rf_out_data is combinational from
//                     rf_read_addr
// -----------------------------------------------------------------------------
module regfile_access_arbiter #(
    parameter  int word_width = 32,
    parameter  int length     = 128,
    parameter  int num_req    = 4,
    localparam int AW         = $clog2(length),
    localparam int PW         = $clog2(num_req)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [num_req-1:0]            req_valid,
    output logic [num_req-1:0]            req_ready,
    input  logic [num_req-1:0]            req_write,
    input  logic [num_req*AW-1:0]         req_addr,
    input  logic [num_req*word_width-1:0] req_wdata,
    output logic [num_req-1:0]            rsp_valid,
    output logic [word_width-1:0]         rsp_data,
    output logic                          busy,
    output logic                          rf_write,
    output logic                          rf_read,
    output logic [AW-1:0]                 rf_write_addr,
    output logic [AW-1:0]                 rf_read_addr,
    output logic [word_width-1:0]         rf_in_data,
    input  logic [word_width-1:0]         rf_out_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t                  state;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           owner;

    logic                    grant_found;
    logic [PW-1:0]           grant_idx;
    logic [PW-1:0]           cand;
    logic [PW-1:0]           next_ptr;
    logic [AW-1:0]           grant_addr;
    logic [word_width-1:0]   grant_wdata;

    // Round-robin search: scan from rr_ptr upward with wrap, first valid wins.
    // NOTE: every variable driven here gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < num_req; k++) begin
            cand = PW'((int'(rr_ptr) + k) % num_req);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        next_ptr    = (grant_idx == PW'(num_req - 1)) ? '0 : grant_idx + 1'b1;
        grant_addr  = req_addr[grant_idx*AW +: AW];
        grant_wdata = req_wdata[grant_idx*word_width +: word_width];

        // Ready is only offered from IDLE, and is forced low while reset is
        // asserted so every output reads zero during reset.
        req_ready = '0;
        if (reset_n && state == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The rf_* registers double as the command latch: loaded on the accept
    // edge, they present the command during ISSUE and clear on leaving it.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the data-path latches are reset along with the control state
        // because all outputs, rsp_data included, must read zero out of reset.
        if (!reset_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            busy          <= 1'b0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rf_write      <= 1'b0;
            rf_read       <= 1'b0;
            rf_write_addr <= '0;
            rf_read_addr  <= '0;
            rf_in_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        state  <= S_ISSUE;
                        busy   <= 1'b1;
                        owner  <= grant_idx;
                        rr_ptr <= next_ptr;
                        if (req_write[grant_idx]) begin
                            rf_write      <= 1'b1;
                            rf_write_addr <= grant_addr;
                            rf_in_data    <= grant_wdata;
                        end else begin
                            rf_read      <= 1'b1;
                            rf_read_addr <= grant_addr;
                        end
                    end
                end

                S_ISSUE: begin
                    rf_write      <= 1'b0;
                    rf_read       <= 1'b0;
                    rf_write_addr <= '0;
                    rf_read_addr  <= '0;
                    rf_in_data    <= '0;
                    if (rf_read) begin
                        rsp_data         <= rf_out_data;
                        rsp_valid[owner] <= 1'b1;
                        state            <= S_RESP;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_RESP: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
